input_prescaler: RTL and testbench

//  Programmable divider clocked by the measured input signal, upstream of frequency_counter.
//  Its oclk output drives frequency_counter.iclk, so inputs faster than the counter fabric can be measured.
//  The division ratio is 2*(div+1), and oclk has a 50% duty cycle.
//  The ratio is set from the system-clock domain with a toggle handshake.
//  A new ratio takes effect only at an oclk period boundary, so oclk never produces a runt pulse.

---
 rtl/input_prescaler_pkg.sv | 9 +
 rtl/input_prescaler_toggle_sync.sv | 28 ++
 rtl/input_prescaler.sv | 88 ++++++++
 tb/tb_input_prescaler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_prescaler_pkg.sv
// rtl/input_prescaler_pkg.sv - shared types for the input prescaler
package input_prescaler_pkg;

  typedef enum logic {
    WAIT_CFG = 1'b0,
    RUN      = 1'b1
  } state_e;

endpackage

// File: rtl/input_prescaler_toggle_sync.sv
// rtl/input_prescaler_toggle_sync.sv - flop chain that brings a toggle level into the local clock domain
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/input_prescaler.sv
// rtl/input_prescaler.sv - divides the measured input by 2*(div+1) with a 50% duty cycle
import input_prescaler_pkg::*;

module input_prescaler #(
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 iclk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 cfg_toggle,
  output logic                 cfg_ack,
  output logic                 oclk,
  output logic                 running
);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
  logic                 oclk_q, oclk_d;
  logic                 cfg_ack_q, cfg_ack_d;
  logic                 sync_q;
  logic                 pending;

  toggle_sync #(
    .STAGES(SYNC_STAGES)
  ) u_toggle_sync (
    .clk  (iclk),
    .reset(reset),
    .d    (cfg_toggle),
    .q    (sync_q)
  );

  assign pending = (sync_q != cfg_ack_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    oclk_d       = oclk_q;
    cfg_ack_d    = cfg_ack_q;
    case (state_q)
      WAIT_CFG: begin
        cnt_d  = '0;
        oclk_d = 1'b0;
        if (pending) begin
          div_active_d = div;
          cfg_ack_d    = sync_q;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (cnt_q == div_active_q) begin
          cnt_d  = '0;
          oclk_d = ~oclk_q;
          // Only a falling edge closes a full period, so a new ratio never cuts a pulse short.
          if (oclk_q && pending) begin
            div_active_d = div;
            cfg_ack_d    = sync_q;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_CFG;
      cnt_q        <= '0;
      div_active_q <= '0;
      oclk_q       <= 1'b0;
      cfg_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      oclk_q       <= oclk_d;
      cfg_ack_q    <= cfg_ack_d;
    end
  end

  assign oclk    = oclk_q;
  assign cfg_ack = cfg_ack_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_input_prescaler.sv
// tb/tb_input_prescaler.sv - randomized self-checking bench for input_prescaler
module tb_input_prescaler;

  localparam int DW   = 12;
  localparam int SYNC = 2;
  localparam int ONES = (1 << DW) - 1;

  logic          iclk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] div = '0;
  logic          cfg_toggle = 1'b0;
  logic          cfg_ack;
  logic          oclk;
  logic          running;

  int tests = 0;
  int failed = 0;

  input_prescaler #(
    .DIV_WIDTH  (DW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .iclk      (iclk),
    .reset     (reset),
    .div       (div),
    .cfg_toggle(cfg_toggle),
    .cfg_ack   (cfg_ack),
    .oclk      (oclk),
    .running   (running)
  );

  always #5 iclk = ~iclk;

  // Reference: oclk is a pure function of edges elapsed since the last apply edge.
  bit m_tq[$];
  bit m_running, m_ack, m_oclk;
  int m_div, m_ea, m_n;

  bit prev_oclk, prev_ack;
  int rise_q[$];
  int fall_q[$];
  int ack_edge;
  int run_len = 1000;
  int min_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, m_n, got, exp);
    end
  endtask

  task automatic model_edge();
    bit sv;
    int k;
    m_n++;
    sv = m_tq.pop_front();
    m_tq.push_back(cfg_toggle);
    if (!m_running) begin
      if (sv != m_ack) begin
        m_running = 1'b1;
        m_ack     = sv;
        m_div     = int'(div);
        m_ea      = m_n;
      end
    end else begin
      k = m_n - m_ea;
      if (k > 0 && k % (2 * (m_div + 1)) == 0 && sv != m_ack) begin
        m_ack = sv;
        m_div = int'(div);
        m_ea  = m_n;
      end
    end
    m_oclk = m_running ? (((m_n - m_ea) / (m_div + 1)) % 2 == 1) : 1'b0;
  endtask

  task automatic tick();
    @(posedge iclk);
    model_edge();
    #1;
    check("oclk", {31'b0, oclk}, {31'b0, m_oclk});
    check("cfg_ack", {31'b0, cfg_ack}, {31'b0, m_ack});
    check("running", {31'b0, running}, {31'b0, m_running});
    if (oclk !== prev_oclk) begin
      if (oclk) rise_q.push_back(m_n);
      else fall_q.push_back(m_n);
      if (run_len < min_run) min_run = run_len;
      run_len = 1;
    end else begin
      run_len++;
    end
    if (cfg_ack !== prev_ack) ack_edge = m_n;
    prev_oclk = oclk;
    prev_ack  = cfg_ack;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    rise_q.delete();
    fall_q.delete();
    min_run = 1000;
  endtask

  task automatic send_cfg(input int d);
    int b = 0;
    while (m_ack != cfg_toggle && b < 20000) begin
      tick();
      b++;
    end
    check("handshake_ready", {31'b0, (m_ack == cfg_toggle)}, 32'd1);
    div        = d[DW-1:0];
    cfg_toggle = ~cfg_toggle;
  endtask

  task automatic do_reset();
    #2;
    reset      = 1'b1;
    cfg_toggle = 1'b0;
    #1;
    check("rst_oclk", {31'b0, oclk}, 32'd0);
    check("rst_ack", {31'b0, cfg_ack}, 32'd0);
    check("rst_running", {31'b0, running}, 32'd0);
    repeat (2) @(posedge iclk);
    #2;
    reset = 1'b0;
    m_tq.delete();
    for (int i = 0; i < SYNC; i++) m_tq.push_back(1'b0);
    m_running = 1'b0;
    m_ack     = 1'b0;
    m_oclk    = 1'b0;
    prev_oclk = 1'b0;
    prev_ack  = 1'b0;
  endtask

  initial begin
    int t0;
    int b;

    // Idle after reset: nothing moves without a request.
    do_reset();
    clear_log();
    ticks(50);
    check("idle_rises", rise_q.size(), 0);

    // First configuration: div=3 from WAIT_CFG.
    t0 = m_n;
    send_cfg(3);
    clear_log();
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 3) begin
        check("ack_edge3", {31'b0, cfg_ack}, 32'd1);
        check("running_edge3", {31'b0, running}, 32'd1);
      end
    end
    check("div3_rises", {31'b0, (rise_q.size() >= 2 && fall_q.size() >= 1)}, 32'd1);
    if (rise_q.size() >= 2 && fall_q.size() >= 1) begin
      check("first_rise", rise_q[0] - t0, 7);
      check("period8", rise_q[1] - rise_q[0], 8);
      check("high4", fall_q[0] - rise_q[0], 4);
    end

    // Ratio 2.
    send_cfg(0);
    ticks(20);
    clear_log();
    ticks(12);
    check("div0_rises", {31'b0, (rise_q.size() >= 2)}, 32'd1);
    if (rise_q.size() >= 2) check("period2", rise_q[1] - rise_q[0], 2);

    // All-ones divider: half period of 2^DW edges.
    send_cfg(ONES);
    ticks(10);
    clear_log();
    ticks(2 * (ONES + 1) + 50);
    check("max_edges", {31'b0, (rise_q.size() >= 1 && fall_q.size() >= 1)}, 32'd1);
    if (rise_q.size() >= 1 && fall_q.size() >= 1) check("max_half", fall_q[0] - rise_q[0], ONES + 1);

    // Mid-high-phase request: the current period must finish first.
    send_cfg(3);
    ticks(2 * (ONES + 1) + 40);
    b = 0;
    while (!(m_oclk && (m_n - m_ea) % 4 == 1) && b < 40) begin
      tick();
      b++;
    end
    check("found_mid_high", {31'b0, (b < 40)}, 32'd1);
    send_cfg(1);
    clear_log();
    ack_edge = -1;
    ticks(40);
    check("mid_edges", {31'b0, (fall_q.size() >= 1 && rise_q.size() >= 3)}, 32'd1);
    if (fall_q.size() >= 1 && rise_q.size() >= 3) begin
      check("ack_on_fall", ack_edge, fall_q[0]);
      check("new_period4", rise_q[2] - rise_q[1], 4);
    end
    check("no_runt", {31'b0, (min_run >= 2)}, 32'd1);

    // Random reconfiguration respecting the one-toggle-per-handshake rule.
    for (int r = 0; r < 25; r++) begin
      send_cfg(int'($urandom_range(0, 9)));
      ticks(int'($urandom_range(0, 40)));
    end

    // Ratio 10 over 1000 edges yields exactly 100 periods.
    send_cfg(4);
    b = 0;
    while (!(m_ack == cfg_toggle && m_div == 4) && b < 200) begin
      tick();
      b++;
    end
    ticks(5);
    clear_log();
    ticks(1000);
    check("ratio10_rises", rise_q.size(), 100);

    // Async reset in the middle of a high phase.
    b = 0;
    while (!m_oclk && b < 30) begin
      tick();
      b++;
    end
    tick();
    check("high_before_rst", {31'b0, oclk}, 32'd1);
    do_reset();
    clear_log();
    ticks(20);
    check("no_resume", {31'b0, running}, 32'd0);
    send_cfg(2);
    ticks(30);
    check("resumed", {31'b0, (rise_q.size() >= 1)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
